data_mem_loader: RTL and testbench

- Hardware counterpart to the end-of-simulation data-memory dump: streams a byte image into the pipeline's 256 x 20-bit data memory before the processor runs.
- Receives bytes over a valid/ready interface, assembles them into 20-bit words, and issues sequential single-cycle writes to the data memory port.
- Holds the processor via `cpu_hold` until the load completes.

---
 rtl/data_mem_loader_if.sv | 30 +++
 rtl/data_mem_loader.sv | 114 +++++++++++
 tb/tb_data_mem_loader.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_loader_if.sv
// Byte-stream ingress and data-memory write port of the loader.
interface data_mem_loader_if #(
    parameter int DATA_WIDTH    = 20,
    parameter int ADDRESS_WIDTH = 8
);
    logic [7:0]               in_data;
    logic                     in_valid;
    logic                     in_ready;
    logic                     mem_write_en;
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]    mem_write_data;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  mem_write_en,
        input  mem_addr,
        input  mem_write_data
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output mem_write_en,
        output mem_addr,
        output mem_write_data
    );
endinterface

// File: rtl/data_mem_loader.sv
// Streams a little-endian byte image into the data memory,
// three bytes per word, holding the CPU until the load is done.
module data_mem_loader #(
    parameter int DATA_WIDTH    = 20,
    parameter int ADDRESS_WIDTH = 8,
    parameter int MEM_SIZE      = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic [ADDRESS_WIDTH-1:0] start_addr,
    input  logic [ADDRESS_WIDTH:0]   load_count,
    data_mem_loader_if.slave         bus,
    output logic                     cpu_hold,
    output logic                     busy,
    output logic                     done,
    output logic                     error
);
    localparam int CW      = ADDRESS_WIDTH + 1;
    localparam int HI_BITS = DATA_WIDTH - 16;
    localparam logic [CW-1:0] MEM_WORDS = CW'(MEM_SIZE);

    typedef enum logic [2:0] {
        IDLE, BYTE0, BYTE1, BYTE2, WRITE, DONE
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [ADDRESS_WIDTH-1:0] addr_cnt;
    logic [CW-1:0]            remaining;
    logic [7:0]               byte0;
    logic [7:0]               byte1;
    logic [7:0]               hi_bits;
    logic                     start_ok;
    logic                     xfer;

    assign start_ok = start && !abort
                   && (state == IDLE || state == DONE);
    assign xfer     = bus.in_valid && bus.in_ready && !abort;
    assign hi_bits  = bus.in_data >> HI_BITS;

    assign bus.in_ready     = (state == BYTE0) || (state == BYTE1)
                           || (state == BYTE2);
    assign bus.mem_write_en = (state == WRITE);
    assign busy             = bus.in_ready || bus.mem_write_en;
    assign cpu_hold         = busy;
    assign done             = (state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE: begin
                if (start_ok)
                    state_nxt = (load_count == '0) ? DONE : BYTE0;
            end
            BYTE0: begin
                if (abort)     state_nxt = IDLE;
                else if (xfer) state_nxt = BYTE1;
            end
            BYTE1: begin
                if (abort)     state_nxt = IDLE;
                else if (xfer) state_nxt = BYTE2;
            end
            BYTE2: begin
                if (abort)     state_nxt = IDLE;
                else if (xfer) state_nxt = WRITE;
            end
            WRITE: begin
                if (abort)                    state_nxt = IDLE;
                else if (remaining == CW'(1)) state_nxt = DONE;
                else                          state_nxt = BYTE0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_cnt           <= '0;
            remaining          <= '0;
            byte0              <= '0;
            byte1              <= '0;
            error              <= 1'b0;
            bus.mem_addr       <= '0;
            bus.mem_write_data <= '0;
        end else begin
            if (start_ok) begin
                addr_cnt  <= start_addr;
                remaining <= (load_count > MEM_WORDS) ? MEM_WORDS
                                                      : load_count;
                error     <= (load_count > MEM_WORDS);
            end
            if (xfer && state == BYTE0) byte0 <= bus.in_data;
            if (xfer && state == BYTE1) byte1 <= bus.in_data;
            // Word and address are captured so they hold after the strobe.
            if (xfer && state == BYTE2) begin
                bus.mem_addr       <= addr_cnt;
                bus.mem_write_data <= {bus.in_data[DATA_WIDTH-17:0],
                                       byte1, byte0};
                if (hi_bits != 8'd0) error <= 1'b1;
            end
            if (state == WRITE) begin
                addr_cnt  <= addr_cnt + ADDRESS_WIDTH'(1);
                remaining <= remaining - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_data_mem_loader.sv
// Directed bench for data_mem_loader with a byte-driver and
// a negedge write monitor feeding a model memory.
module tb_data_mem_loader;
    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] start_addr;
    logic [8:0] load_count;
    logic       cpu_hold;
    logic       busy;
    logic       done;
    logic       error;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int wcount = 0;
    int wcyc_last = 0;
    int wcyc_prev = 0;
    logic [19:0] tb_mem [256];

    data_mem_loader_if #(.DATA_WIDTH(20), .ADDRESS_WIDTH(8)) bus ();

    data_mem_loader #(
        .DATA_WIDTH(20), .ADDRESS_WIDTH(8), .MEM_SIZE(256)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .start_addr (start_addr),
        .load_count (load_count),
        .bus        (bus),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.mem_write_en === 1'b1) begin
            tb_mem[bus.mem_addr] = bus.mem_write_data;
            wcount++;
            wcyc_prev = wcyc_last;
            wcyc_last = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (bus.in_ready !== 1'b1) begin
            total++;
            $error("FAIL in_ready_timeout: observed %b expected 1",
                   bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_start(input logic [7:0] a, input logic [8:0] n);
        start_addr = a;
        load_count = n;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic chk_write(input string tag, input logic [7:0] a,
                             input logic [19:0] d);
        chk({tag, "_en"},   32'(bus.mem_write_en), 32'd1);
        chk({tag, "_addr"}, 32'(bus.mem_addr), 32'(a));
        chk({tag, "_data"}, 32'(bus.mem_write_data), 32'(d));
    endtask

    initial begin
        int w0;
        foreach (tb_mem[i]) tb_mem[i] = '0;
        rst          = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        start_addr   = '0;
        load_count   = '0;
        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        repeat (3) tick();
        chk("reset_outputs",
            {bus.in_ready, bus.mem_write_en, busy, done, cpu_hold, error,
             bus.mem_addr, bus.mem_write_data}, 32'd0);
        rst = 1'b1;
        tick();

        // Two words, continuous valid
        pulse_start(8'h00, 9'd2);
        chk("t1_hold_after_start", {30'd0, busy, cpu_hold}, 32'd3);
        send_byte(8'h34);
        send_byte(8'h12);
        send_byte(8'h05);
        chk_write("t1_w0", 8'h00, 20'h51234);
        send_byte(8'hCD);
        send_byte(8'hAB);
        send_byte(8'h0F);
        chk_write("t1_w1", 8'h01, 20'hFABCD);
        tick();
        chk("t1_spacing", 32'(wcyc_last - wcyc_prev), 32'd4);
        chk("t1_done_flags", {29'd0, done, cpu_hold, error}, 32'b100);
        chk("t1_mem", {12'd0, tb_mem[8'h01]}, 32'hFABCD);
        bus.in_valid = 1'b1;
        tick();
        chk("t1_no_ready_in_done", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b0;

        // Address wrap
        w0 = wcount;
        pulse_start(8'hFE, 9'd3);
        send_byte(8'h45); send_byte(8'h23); send_byte(8'h01);
        send_byte(8'h9A); send_byte(8'h78); send_byte(8'h06);
        send_byte(8'hEF); send_byte(8'hCD); send_byte(8'h0B);
        chk_write("t2_wrap", 8'h00, 20'hBCDEF);
        tick();
        chk("t2_count", 32'(wcount - w0), 32'd3);
        chk("t2_mem_fe", {12'd0, tb_mem[8'hFE]}, 32'h12345);
        chk("t2_mem_ff", {12'd0, tb_mem[8'hFF]}, 32'h6789A);
        chk("t2_mem_00", {12'd0, tb_mem[8'h00]}, 32'hBCDEF);

        // Gapped valid
        w0 = wcount;
        pulse_start(8'h10, 9'd1);
        bus.in_data = 8'h01; bus.in_valid = 1'b1; tick();
        bus.in_valid = 1'b0; tick();
        chk("t3_ready_gap1", {30'd0, bus.in_ready, bus.mem_write_en},
            32'b10);
        tick();
        bus.in_data = 8'h02; bus.in_valid = 1'b1; tick();
        bus.in_valid = 1'b0; tick();
        chk("t3_ready_gap2", {30'd0, bus.in_ready, bus.mem_write_en},
            32'b10);
        chk("t3_no_early_write", 32'(wcount - w0), 32'd0);
        bus.in_data = 8'h03; bus.in_valid = 1'b1; tick();
        bus.in_valid = 1'b0;
        chk_write("t3_w", 8'h10, 20'h30201);
        tick();
        chk("t3_done", 32'(done), 32'd1);

        // Nonzero high nibble
        pulse_start(8'h20, 9'd1);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'hA7);
        chk_write("t4_nib", 8'h20, 20'h72211);
        repeat (3) tick();
        chk("t4_err_sticky", {30'd0, done, error}, 32'b11);
        w0 = wcount;
        pulse_start(8'h30, 9'd0);
        chk("t4_zero_count", {30'd0, done, error}, 32'b10);
        repeat (3) tick();
        chk("t4_zero_no_write", 32'(wcount - w0), 32'd0);

        // Oversized count clamps to the full memory
        w0 = wcount;
        pulse_start(8'h00, 9'h1FF);
        chk("t4_clamp_err", {30'd0, busy, error}, 32'b11);
        for (int i = 0; i < 256; i++) begin
            send_byte(8'(i));
            send_byte(8'hC3);
            send_byte({4'h0, 4'(i)});
        end
        tick();
        chk("t4_clamp_count", 32'(wcount - w0), 32'd256);
        chk("t4_clamp_mem00", {12'd0, tb_mem[8'h00]}, 32'h0C300);
        chk("t4_clamp_memff", {12'd0, tb_mem[8'hFF]}, 32'hFC3FF);
        chk("t4_clamp_end", {29'd0, done, busy, error}, 32'b101);

        // Abort inside the third word
        w0 = wcount;
        pulse_start(8'h40, 9'd5);
        send_byte(8'hB3); send_byte(8'h2A); send_byte(8'h01);
        send_byte(8'hD6); send_byte(8'h5D); send_byte(8'h04);
        send_byte(8'h77); send_byte(8'h88);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_abort_flags",
            {28'd0, busy, done, cpu_hold, bus.in_ready}, 32'd0);
        repeat (3) tick();
        chk("t5_abort_writes", 32'(wcount - w0), 32'd2);
        chk("t5_mem41", {12'd0, tb_mem[8'h41]}, 32'h45DD6);
        start_addr = 8'h00; load_count = 9'd0;
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("t5_abort_beats_start", {30'd0, busy, done}, 32'd0);

        // Start while busy is ignored
        pulse_start(8'h50, 9'd1);
        send_byte(8'h01);
        pulse_start(8'h60, 9'd0);
        chk("t5_start_ignored", {29'd0, busy, done, bus.in_ready}, 32'b101);
        send_byte(8'h02); send_byte(8'h03);
        chk_write("t5_repeat", 8'h50, 20'h30201);
        tick();

        // Asynchronous reset mid-word
        pulse_start(8'h70, 9'd2);
        send_byte(8'h11);
        #3 rst = 1'b0;
        #1;
        chk("t6_async_reset",
            {bus.in_ready, bus.mem_write_en, busy, done, cpu_hold, error,
             bus.mem_addr, bus.mem_write_data}, 32'd0);
        tick();
        rst = 1'b1;
        w0 = wcount;
        pulse_start(8'h80, 9'd0);
        chk("t6_zero_done", {30'd0, done, busy}, 32'b10);
        repeat (3) tick();
        chk("t6_no_write", 32'(wcount - w0), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
